// File: rtl/logicnet_seq_pkg.sv
// Shared types and helpers for the LogicNet layer sequencer.
package logicnet_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WAIT_W = 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/logicnet_seq_perf.sv
// Saturating inference/stall counters for the layer sequencer.
module logicnet_seq_perf
  import logicnet_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        infer_evt,
  input  logic        stall_evt,
  output logic [31:0] perf_infer_cnt,
  output logic [31:0] perf_stall_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_infer_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (infer_evt) perf_infer_cnt <= sat_inc(perf_infer_cnt);
      if (stall_evt) perf_stall_cnt <= sat_inc(perf_stall_cnt);
    end
  end

endmodule

// File: rtl/logicnet_layer_sequencer.sv
// Steps one inference through NUM_LAYERS LUT layers, feeding each result back.
// Optional counters enabled by LOGICNET_SEQ_PERF_EN.
module logicnet_layer_sequencer
  import logicnet_seq_pkg::*;
#(
  parameter int ACT_W      = 64,
  parameter int NUM_LAYERS = 5,
  parameter int LUT_LAT    = 1,
  parameter int LSEL_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACT_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACT_W-1:0]  out_data,
  input  logic              flush,
  output logic              lut_en,
  output logic [LSEL_W-1:0] lut_layer_sel,
  output logic [ACT_W-1:0]  lut_in,
  input  logic [ACT_W-1:0]  lut_out,
  output logic              busy
`ifdef LOGICNET_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_infer_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  if (NUM_LAYERS < 1 || LUT_LAT < 0 || LUT_LAT > 3 || (1 << LSEL_W) < NUM_LAYERS) begin : g_bad_cfg
    $error("logicnet_layer_sequencer: illegal NUM_LAYERS/LUT_LAT/LSEL_W");
  end

  localparam logic [WAIT_W-1:0] LAT_MAX    = WAIT_W'(LUT_LAT);
  localparam logic [LSEL_W-1:0] LAST_LAYER = LSEL_W'(NUM_LAYERS - 1);

  state_t             state_q, state_d;
  logic [ACT_W-1:0]   act_q;
  logic [LSEL_W-1:0]  layer_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               lut_sample;

  assign lut_sample = (state_q == EVAL) && (wait_q == LAT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid)                               state_d = EVAL;
        EVAL:    if (lut_sample && layer_q == LAST_LAYER)     state_d = DONE;
        DONE:    if (out_ready)                              state_d = IDLE;
        default:                                             state_d = IDLE;
      endcase
    end
  end

  // Flush clears the counters but keeps the last activation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q   <= '0;
      layer_q <= '0;
      wait_q  <= '0;
    end else if (flush) begin
      layer_q <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          act_q   <= in_data;
          layer_q <= '0;
          wait_q  <= '0;
        end
        EVAL: if (lut_sample) begin
          act_q  <= lut_out;
          wait_q <= '0;
          if (layer_q != LAST_LAYER) layer_q <= layer_q + LSEL_W'(1);
        end else begin
          wait_q <= wait_q + WAIT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the block
  // leaves a value unassigned and infers a latch.
  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    lut_en        = 1'b0;
    lut_layer_sel = '0;
    busy          = 1'b0;
    lut_in        = act_q;
    case (state_q)
      IDLE: in_ready = 1'b1;
      EVAL: begin
        lut_en        = 1'b1;
        lut_layer_sel = layer_q;
        busy          = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = act_q;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef LOGICNET_SEQ_PERF_EN
  // A handshake coinciding with flush is abandoned, so it is not counted.
  logicnet_seq_perf u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .infer_evt      ((state_q == DONE) && out_ready && !flush),
    .stall_evt      ((state_q == DONE) && !out_ready),
    .perf_infer_cnt (perf_infer_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_logicnet_layer_sequencer.sv
// Bench for logicnet_layer_sequencer: LUT_LAT=1 and LUT_LAT=0 instances against
// a fold-over-layers reference model.
module tb_logicnet_layer_sequencer;

  localparam int ACT_W  = 64;
  localparam int NL     = 5;
  localparam int LSEL_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_lut_en, a_busy;
  logic [ACT_W-1:0]  a_in_data, a_out_data, a_lut_in, a_lut_out;
  logic [LSEL_W-1:0] a_sel;
  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_lut_en, b_busy;
  logic [ACT_W-1:0]  b_in_data, b_out_data, b_lut_in, b_lut_out;
  logic [LSEL_W-1:0] b_sel;
`ifdef LOGICNET_SEQ_PERF_EN
  logic [31:0] a_perf_infer, a_perf_stall, b_perf_infer, b_perf_stall;
`endif

  logicnet_layer_sequencer #(.ACT_W(ACT_W), .NUM_LAYERS(NL), .LUT_LAT(1), .LSEL_W(LSEL_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .flush(a_flush),
    .lut_en(a_lut_en), .lut_layer_sel(a_sel), .lut_in(a_lut_in), .lut_out(a_lut_out), .busy(a_busy)
`ifdef LOGICNET_SEQ_PERF_EN
    , .perf_infer_cnt(a_perf_infer), .perf_stall_cnt(a_perf_stall)
`endif
  );

  logicnet_layer_sequencer #(.ACT_W(ACT_W), .NUM_LAYERS(NL), .LUT_LAT(0), .LSEL_W(LSEL_W)) u_dut_lat0 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .flush(b_flush),
    .lut_en(b_lut_en), .lut_layer_sel(b_sel), .lut_in(b_lut_in), .lut_out(b_lut_out), .busy(b_busy)
`ifdef LOGICNET_SEQ_PERF_EN
    , .perf_infer_cnt(b_perf_infer), .perf_stall_cnt(b_perf_stall)
`endif
  );

  // Bank models: one registered stage for instance A, purely combinational for B.
  always_ff @(posedge clk) a_lut_out <= a_lut_in + ACT_W'(a_sel) + ACT_W'(1);
  assign b_lut_out = b_lut_in ^ ACT_W'(b_sel);

  int total = 0;
  int bad   = 0;
  logic [LSEL_W:0] sel_log[$];

  function automatic logic [ACT_W-1:0] model_a(input logic [ACT_W-1:0] d);
    for (int l = 0; l < NL; l++) d = d + ACT_W'(l) + ACT_W'(1);
    return d;
  endfunction

  function automatic logic [ACT_W-1:0] model_b(input logic [ACT_W-1:0] d);
    for (int l = 0; l < NL; l++) d = d ^ ACT_W'(l);
    return d;
  endfunction

  function automatic logic [ACT_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Drive one input at a negedge; it is accepted on the following posedge.
  task automatic accept_a(input logic [ACT_W-1:0] d);
    a_in_valid = 1'b1; a_in_data = d;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0; a_in_data = rnd64();
  endtask

  task automatic accept_b(input logic [ACT_W-1:0] d);
    b_in_valid = 1'b1; b_in_data = d;
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0; b_in_data = rnd64();
  endtask

  // Counts posedges until out_valid is seen; -1 when the budget expires.
  task automatic wait_out_a(output int n);
    n = 0; sel_log.delete();
    while (!a_out_valid && n < 200) begin
      sel_log.push_back({a_lut_en, a_sel});
      @(posedge clk); n++; @(negedge clk);
    end
    if (!a_out_valid) n = -1;
  endtask

  task automatic wait_out_b(output int n);
    n = 0;
    while (!b_out_valid && n < 200) begin
      @(posedge clk); n++; @(negedge clk);
    end
    if (!b_out_valid) n = -1;
  endtask

  task automatic release_a();
    a_out_ready = 1'b1; @(posedge clk); @(negedge clk); a_out_ready = 1'b0;
  endtask

  task automatic release_b();
    b_out_ready = 1'b1; @(posedge clk); @(negedge clk); b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    total++; if (a_out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
    total++; if (a_lut_en !== 1'b0) begin bad++; $display("FAIL reset_lut_en: got %b want 0", a_lut_en); end
    total++; if (a_sel !== '0) begin bad++; $display("FAIL reset_sel: got %0d want 0", a_sel); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
`ifdef LOGICNET_SEQ_PERF_EN
    total++; if (a_perf_infer !== 0 || a_perf_stall !== 0) begin bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", a_perf_infer, a_perf_stall); end
`endif
  endtask

  task automatic test_single();
    int n;
    accept_a('0);
    wait_out_a(n);
    total++; if (n !== NL * 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", n, NL * 2); end
    total++; if (a_out_data !== model_a('0)) begin bad++; $display("FAIL single_data: got %h want %h", a_out_data, model_a('0)); end
    total++; if (sel_log.size() !== NL * 2) begin bad++; $display("FAIL single_sel_len: got %0d want %0d", sel_log.size(), NL * 2); end
    for (int k = 0; k < sel_log.size() && k < NL * 2; k++) begin
      total++;
      if (sel_log[k] !== {1'b1, LSEL_W'(k / 2)}) begin
        bad++; $display("FAIL single_sel[%0d]: got en/sel %h want %h", k, sel_log[k], {1'b1, LSEL_W'(k / 2)});
      end
    end
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL single_in_ready_done: got %b want 0", a_in_ready); end
    release_a();
    total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin bad++; $display("FAIL single_after_hs: in_ready=%b out_valid=%b want 1/0", a_in_ready, a_out_valid); end
  endtask

  task automatic test_backpressure();
    int n;
    logic [ACT_W-1:0] d, exp;
`ifdef LOGICNET_SEQ_PERF_EN
    logic [31:0] s0, i0;
`endif
    d = rnd64(); exp = model_a(d);
    accept_a(d);
    wait_out_a(n);
    total++; if (n !== NL * 2) begin bad++; $display("FAIL bp_latency: got %0d want %0d", n, NL * 2); end
`ifdef LOGICNET_SEQ_PERF_EN
    s0 = a_perf_stall; i0 = a_perf_infer;
`endif
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp || a_in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: valid=%b data=%h in_ready=%b want 1/%h/0", c, a_out_valid, a_out_data, a_in_ready, exp);
      end
    end
    release_a();
`ifdef LOGICNET_SEQ_PERF_EN
    total++; if (a_perf_stall - s0 !== 32'd7) begin bad++; $display("FAIL bp_stall_cnt: got %0d want 7", a_perf_stall - s0); end
    total++; if (a_perf_infer - i0 !== 32'd1) begin bad++; $display("FAIL bp_infer_cnt: got %0d want 1", a_perf_infer - i0); end
`endif
  endtask

  task automatic test_lat0();
    int n;
    logic [ACT_W-1:0] d;
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? ACT_W'(5) : rnd64();
      accept_b(d);
      wait_out_b(n);
      total++; if (n !== NL) begin bad++; $display("FAIL lat0_latency[%0d]: got %0d want %0d", i, n, NL); end
      total++; if (b_out_data !== model_b(d)) begin bad++; $display("FAIL lat0_data[%0d]: got %h want %h", i, b_out_data, model_b(d)); end
      release_b();
    end
  endtask

  task automatic test_flush();
    int n, guard, seen;
    logic [ACT_W-1:0] d;
    accept_a(rnd64());
    guard = 0;
    while (!(a_lut_en && a_sel == LSEL_W'(2)) && guard < 50) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    total++; if (guard >= 50) begin bad++; $display("FAIL flush_reach_layer2: timeout sel=%0d", a_sel); end
    a_flush = 1'b1; @(posedge clk); @(negedge clk); a_flush = 1'b0;
    total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      bad++; $display("FAIL flush_idle: in_ready=%b out_valid=%b busy=%b want 1/0/0", a_in_ready, a_out_valid, a_busy);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); @(negedge clk);
      if (a_out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_output: got %0d valid cycles want 0", seen); end
    d = rnd64();
    accept_a(d);
    wait_out_a(n);
    total++; if (n !== NL * 2 || a_out_data !== model_a(d)) begin
      bad++; $display("FAIL flush_next: latency %0d data %h want %0d/%h", n, a_out_data, NL * 2, model_a(d));
    end
    release_a();
  endtask

  task automatic test_flush_handshake();
    int n;
`ifdef LOGICNET_SEQ_PERF_EN
    logic [31:0] i0;
`endif
    accept_a(rnd64());
    wait_out_a(n);
    total++; if (n !== NL * 2) begin bad++; $display("FAIL fhs_latency: got %0d want %0d", n, NL * 2); end
`ifdef LOGICNET_SEQ_PERF_EN
    i0 = a_perf_infer;
`endif
    a_flush = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_flush = 1'b0; a_out_ready = 1'b0;
    total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      bad++; $display("FAIL fhs_idle: in_ready=%b out_valid=%b busy=%b want 1/0/0", a_in_ready, a_out_valid, a_busy);
    end
`ifdef LOGICNET_SEQ_PERF_EN
    total++; if (a_perf_infer !== i0) begin bad++; $display("FAIL fhs_infer_cnt: got %0d want %0d", a_perf_infer, i0); end
`endif
  endtask

  task automatic test_async_reset();
    accept_a(rnd64());
    repeat (3) begin @(posedge clk); @(negedge clk); end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy: got %b want 1", a_busy); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_lut_en !== 1'b0 || a_busy !== 1'b0) begin
      bad++; $display("FAIL arst_ctrl: in_ready=%b out_valid=%b lut_en=%b busy=%b want 1/0/0/0", a_in_ready, a_out_valid, a_lut_en, a_busy);
    end
    total++; if (a_sel !== '0 || a_out_data !== '0 || a_lut_in !== '0) begin
      bad++; $display("FAIL arst_data: sel=%0d out=%h lut_in=%h want 0/0/0", a_sel, a_out_data, a_lut_in);
    end
`ifdef LOGICNET_SEQ_PERF_EN
    total++; if (a_perf_infer !== 0 || a_perf_stall !== 0) begin bad++; $display("FAIL arst_perf: got %0d/%0d want 0/0", a_perf_infer, a_perf_stall); end
`endif
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [ACT_W-1:0] d[3];
    logic [ACT_W-1:0] got[$];
    int idx, overlap;
    logic acc;
`ifdef LOGICNET_SEQ_PERF_EN
    logic [31:0] i0;
    i0 = a_perf_infer;
`endif
    for (int i = 0; i < 3; i++) d[i] = rnd64();
    idx = 0; overlap = 0;
    a_in_valid = 1'b1; a_in_data = d[0]; a_out_ready = 1'b1;
    acc = a_in_valid && a_in_ready;
    for (int c = 0; c < 300 && got.size() < 3; c++) begin
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) a_in_data = d[idx];
        else a_in_valid = 1'b0;
      end
      if (a_out_valid) got.push_back(a_out_data);
      if (a_in_ready && a_busy) overlap++;
      acc = a_in_valid && a_in_ready;
    end
    @(posedge clk); @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b0;
    total++; if (idx !== 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", idx); end
    total++; if (got.size() !== 3) begin bad++; $display("FAIL b2b_outputs: got %0d want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      total++; if (got[i] !== model_a(d[i])) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got[i], model_a(d[i])); end
    end
    total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
`ifdef LOGICNET_SEQ_PERF_EN
    total++; if (a_perf_infer - i0 !== 32'd3) begin bad++; $display("FAIL b2b_infer_cnt: got %0d want 3", a_perf_infer - i0); end
`endif
  endtask

  task automatic test_random();
    int n;
    logic [ACT_W-1:0] d;
    for (int i = 0; i < 6; i++) begin
      d = rnd64();
      accept_a(d);
      wait_out_a(n);
      total++; if (n !== NL * 2) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, n, NL * 2); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
      total++; if (a_out_data !== model_a(d)) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, a_out_data, model_a(d)); end
      release_a();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_lat0();
    test_flush();
    test_flush_handshake();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logicnet_layer_sequencer.md
Name: logicnet_layer_sequencer

Overview:
- Time-multiplexes one inference through a bank of per-layer LogicNet LUT neuron layers, one layer at a time, feeding each layer's output back as the next layer's input.
- Sits between the input activation source (valid/ready stream) and the classifier argmax stage (valid/ready stream).
- Drives an external layer-select/LUT bank: ens*_layer*_N* LUT modules muxed by layer index, combinational or registered.

Parameters:
- ACT_W, 64, width of the activation vector passed between layers (widest layer; narrower layers zero-padded in MSBs by the bank).
- NUM_LAYERS, 5, number of LUT layers evaluated per inference (>=1).
- LUT_LAT, 1, cycles from lut_in/lut_layer_sel stable to lut_out valid (0..3).
- LSEL_W, 3, width of lut_layer_sel; must satisfy 2**LSEL_W >= NUM_LAYERS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input activation valid.
- in_ready  out  1  sequencer can accept an input.
- in_data  in  ACT_W  input activation vector (layer 0 input).
- out_valid  out  1  final-layer result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACT_W  final-layer output vector.
- flush  in  1  synchronous abort; returns to IDLE.
- lut_en  out  1  LUT bank enable (high in EVAL only).
- lut_layer_sel  out  LSEL_W  layer index currently evaluated.
- lut_in  out  ACT_W  activation presented to the bank (= act_q).
- lut_out  in  ACT_W  bank result for lut_layer_sel.
- busy  out  1  high in EVAL or DONE.

Behaviour:
- Clock/reset: single clk domain; rst_n asynchronous assert, active-low, synchronous deassert handled upstream.
- Reset values: state=IDLE, act_q=0, layer counter=0, wait counter=0; in_ready=1, out_valid=0, out_data=0, lut_en=0, lut_layer_sel=0, busy=0.
- States: IDLE, EVAL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge T, act_q<=in_data, layer=0, wait=0, go EVAL.
- EVAL: lut_en=1, lut_layer_sel=layer, lut_in=act_q. Wait counter counts 0..LUT_LAT. At wait==LUT_LAT: act_q<=lut_out, wait<=0. Then if layer==NUM_LAYERS-1, go DONE; else layer<=layer+1.
- DONE: out_valid=1, out_data=act_q held stable until out_ready. On out_valid&&out_ready, go IDLE; in_ready stays 0 during DONE, so no back-to-back overlap.
- Latency: out_valid rises NUM_LAYERS*(LUT_LAT+1) edges after acceptance; defaults give 10 cycles.
- Throughput: one inference per NUM_LAYERS*(LUT_LAT+1)+2 cycles minimum.
- in_data is ignored outside IDLE. out_ready is ignored outside DONE.
- flush high in any state: next state IDLE, out_valid<=0, layer<=0, wait<=0; act_q retained. flush has priority over acceptance and completion in the same cycle.
- Mid-operation reset: immediately forces reset values; partial results are discarded.
- Counters: layer counter LSEL_W bits, wait counter 2 bits; no wrap occurs because bounds are checked before increment.
- Elaboration error if NUM_LAYERS<1, LUT_LAT>3, or 2**LSEL_W<NUM_LAYERS.

Optional Feature:
- Macro LOGICNET_SEQ_PERF_EN.
- When defined: adds outputs perf_infer_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_infer_cnt increments on each out handshake.
  - perf_stall_cnt increments on each DONE cycle with out_ready=0.
  - Both saturate at 32'hFFFFFFFF, reset to 0 on rst_n low, and are unaffected by flush.
- When undefined: ports and logic are absent; the core behaviour is identical.

Decomposition:
- Package logicnet_seq_pkg: state enum (IDLE, EVAL, DONE), WAIT_W=2 localparam, saturating-increment function.
- One sub-module, logicnet_seq_perf: the two saturating counters, instantiated only under LOGICNET_SEQ_PERF_EN.

Test Plan:
- Reset then single inference: NUM_LAYERS=5, LUT_LAT=1; bank model returns lut_out = lut_in + layer + 1; in_data=0 -> out_valid 10 cycles after accept, out_data=15; lut_layer_sel sequence 0,0,1,1,2,2,3,3,4,4.
- Backpressure: hold out_ready=0 for 7 cycles in DONE -> out_data stable and in_ready=0 throughout; with PERF_EN, perf_stall_cnt=7 and perf_infer_cnt=1 after release.
- LUT_LAT=0: in_data=8'h05, bank returns lut_in^layer -> out_valid 5 cycles after accept, out_data=5^0^1^2^3^4=5^4=1.
- Flush mid-EVAL at layer 2 -> IDLE next cycle, out_valid never asserts, in_ready=1; the next inference completes correctly from its own in_data.
- Simultaneous flush and out handshake in DONE -> IDLE, perf_infer_cnt not incremented. Async rst_n pulse mid-EVAL -> all outputs at reset values within the same cycle.
- Back-to-back: in_valid held high with 3 inputs -> each accepted only in IDLE; 3 outputs in order; perf_infer_cnt=3.
